// File: rtl/cep_uart_tx.sv
// UART 8N1 transmitter with RTS/CTS handshake and a byte holding register.
// Latency: RTS one cycle after tx_start; start bit one cycle after CTS seen in REQ; frame is 10*CLKS_PER_BIT cycles.
// Backpressure: waits in REQ with RTS high for as long as CTS stays low; CTS is ignored once the frame has started.
module cep_uart_tx #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic       CLK,
    input  logic       rst,
    input  logic       en,
    input  logic       tx_start,
    input  logic [7:0] data,
    input  logic       CTS,
    output logic       RTS,
    output logic       serial_out
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        START = 3'd2,
        DATA  = 3'd3,
        STOP  = 3'd4
    } state_t;

    localparam logic [15:0] BAUD_MAX = 16'(CLKS_PER_BIT - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_hold;
    logic [7:0]  r_shift;
    logic [7:0]  w_shift_nxt;
    logic [2:0]  r_bit;
    logic [2:0]  w_bit_nxt;
    logic [15:0] r_baud;
    logic [15:0] w_baud_nxt;
    logic        r_rts;
    logic        r_serial;
    logic        w_rts_nxt;
    logic        w_serial_nxt;
    logic        w_bit_done;

    assign w_bit_done = (r_baud == BAUD_MAX);
    assign RTS        = r_rts;
    assign serial_out = r_serial;

    // Holding register: captured on every en, independent of the frame in flight.
    always_ff @(posedge CLK) begin
        if (!rst) begin
            r_hold <= 8'h00;
        end else if (en) begin
            r_hold <= data;
        end
    end

    // Next-state, shift/bit/baud updates, and next values of the registered outputs.
    always_comb begin
        w_state_nxt  = r_state;
        w_shift_nxt  = r_shift;
        w_bit_nxt    = r_bit;
        w_baud_nxt   = r_baud;
        w_rts_nxt    = 1'b0;
        w_serial_nxt = 1'b1;

        case (r_state)
            IDLE: begin
                if (tx_start) begin
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                if (CTS) begin
                    w_state_nxt = START;
                    w_shift_nxt = r_hold;
                    w_bit_nxt   = 3'd0;
                    w_baud_nxt  = 16'd0;
                end
            end
            START: begin
                if (w_bit_done) begin
                    w_state_nxt = DATA;
                    w_bit_nxt   = 3'd0;
                    w_baud_nxt  = 16'd0;
                end else begin
                    w_baud_nxt  = r_baud + 16'd1;
                end
            end
            DATA: begin
                if (w_bit_done) begin
                    w_baud_nxt  = 16'd0;
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    w_bit_nxt   = r_bit + 3'd1;
                    if (r_bit == 3'd7) begin
                        w_state_nxt = STOP;
                    end
                end else begin
                    w_baud_nxt  = r_baud + 16'd1;
                end
            end
            STOP: begin
                if (w_bit_done) begin
                    w_state_nxt = IDLE;
                    w_baud_nxt  = 16'd0;
                end else begin
                    w_baud_nxt  = r_baud + 16'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they appear in the same cycle as the state change.
        w_rts_nxt = (w_state_nxt != IDLE);
        case (w_state_nxt)
            START:   w_serial_nxt = 1'b0;
            DATA:    w_serial_nxt = w_shift_nxt[0];
            default: w_serial_nxt = 1'b1;
        endcase
    end

    // State, datapath and output registers; reset aborts any frame and returns the line to idle.
    always_ff @(posedge CLK) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_shift  <= 8'h00;
            r_bit    <= 3'd0;
            r_baud   <= 16'd0;
            r_rts    <= 1'b0;
            r_serial <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_shift  <= w_shift_nxt;
            r_bit    <= w_bit_nxt;
            r_baud   <= w_baud_nxt;
            r_rts    <= w_rts_nxt;
            r_serial <= w_serial_nxt;
        end
    end

endmodule

// File: tb/tb_cep_uart_tx.sv
// Self-checking bench for cep_uart_tx: two instances (1 and 4 clocks per bit) share stimulus.
// A transaction-level model predicts RTS and serial_out every cycle from frame position arithmetic.
// Directed scenarios cover reset, handshake waits, mid-frame disturbance and reset mid-frame, then random traffic.
module tb_cep_uart_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       tx_start;
    logic [7:0] data;
    logic       cts0;
    logic       cts1;
    logic       rts0;
    logic       rts1;
    logic       ser0;
    logic       ser1;

    always #5 clk = ~clk;

    cep_uart_tx #(.CLKS_PER_BIT(1)) u_dut1 (
        .CLK(clk), .rst(rst), .en(en), .tx_start(tx_start), .data(data),
        .CTS(cts0), .RTS(rts0), .serial_out(ser0)
    );

    cep_uart_tx #(.CLKS_PER_BIT(4)) u_dut4 (
        .CLK(clk), .rst(rst), .en(en), .tx_start(tx_start), .data(data),
        .CTS(cts1), .RTS(rts1), .serial_out(ser1)
    );

    // Reference model: phase 0 = idle, 1 = requesting, 2 = frame in flight (m_t cycles elapsed).
    int         cpb[2]     = '{1, 4};
    int         m_phase[2] = '{0, 0};
    int         m_t[2]     = '{0, 0};
    logic [7:0] m_hold[2]  = '{8'h00, 8'h00};
    logic [7:0] m_byte[2]  = '{8'h00, 8'h00};
    bit         follow[2]  = '{1'b0, 1'b0};

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        return 1'b1;
    endfunction

    function automatic logic get_cts(input int i);
        return (i == 0) ? cts0 : cts1;
    endfunction

    function automatic logic get_rts(input int i);
        return (i == 0) ? rts0 : rts1;
    endfunction

    function automatic logic get_ser(input int i);
        return (i == 0) ? ser0 : ser1;
    endfunction

    // One clock: advance the model on the rising edge, compare on the falling edge.
    task automatic step();
        logic [7:0] old_hold;
        logic       exp_ser;
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (!rst) begin
                m_phase[i] = 0;
                m_t[i]     = 0;
                m_hold[i]  = 8'h00;
                m_byte[i]  = 8'h00;
            end else begin
                old_hold = m_hold[i];
                if (en) m_hold[i] = data;
                case (m_phase[i])
                    0: if (tx_start) m_phase[i] = 1;
                    1: if (get_cts(i)) begin
                        m_phase[i] = 2;
                        m_t[i]     = 0;
                        m_byte[i]  = old_hold;
                    end
                    default: begin
                        m_t[i]++;
                        if (m_t[i] == 10 * cpb[i]) m_phase[i] = 0;
                    end
                endcase
            end
        end
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            exp_ser = (m_phase[i] == 2) ? frame_bit(m_byte[i], m_t[i] / cpb[i]) : 1'b1;
            chk($sformatf("rts_dut%0d", i), int'(get_rts(i)), int'(m_phase[i] != 0));
            chk($sformatf("ser_dut%0d", i), int'(get_ser(i)), int'(exp_ser));
        end
        if (follow[0]) cts0 = rts0;
        if (follow[1]) cts1 = rts1;
    endtask

    // Waits (bounded) for the start bit on instance i, then checks the 10 frame bits at bit boundaries.
    task automatic expect_frame(input int i, input logic [9:0] pat, input string tag);
        int w;
        w = 0;
        while (get_ser(i) !== 1'b0 && w < 50) begin
            step();
            w++;
        end
        chk({tag, "_start_seen"}, int'(w < 50), 1);
        if (w < 50) begin
            for (int k = 0; k < 10; k++) begin
                chk($sformatf("%s_bit%0d", tag, k), int'(get_ser(i)), int'(pat[k]));
                repeat (cpb[i]) step();
            end
        end
    endtask

    initial begin
        int w;
        rst = 1'b0; en = 1'b0; tx_start = 1'b0; data = 8'h00; cts0 = 1'b0; cts1 = 1'b0;

        // Reset and idle hold.
        @(negedge clk);
        step();
        rst = 1'b1;
        repeat (10) step();
        chk("reset_rts", int'(rts0), 0);
        chk("reset_ser", int'(ser0), 1);

        // Load 0x6B, change data without en, send with CTS following RTS.
        follow[0] = 1'b1; follow[1] = 1'b1;
        en = 1'b1; data = 8'h6B; step();
        en = 1'b0; data = 8'h00; tx_start = 1'b1; step();
        tx_start = 1'b0;
        chk("t2_rts_rise", int'(rts0), 1);
        expect_frame(0, 10'b1011010110, "t2_6b");
        repeat (50) step();
        chk("t2_rts_fall", int'(rts0), 0);

        // Flow control: CTS held low for 20 cycles, then released.
        follow[0] = 1'b0; follow[1] = 1'b0; cts0 = 1'b0; cts1 = 1'b0;
        en = 1'b1; data = 8'h00; step();
        en = 1'b0; tx_start = 1'b1; step();
        tx_start = 1'b0;
        repeat (20) begin
            step();
            chk("t3_wait_rts", int'(rts0), 1);
            chk("t3_wait_ser", int'(ser0), 1);
        end
        cts0 = 1'b1; cts1 = 1'b1; step();
        chk("t3_start_bit", int'(ser0), 0);

        // Mid-frame: reload 0xFF, pulse tx_start, drop CTS; frame in flight must stay 0x00.
        repeat (3) step();
        en = 1'b1; data = 8'hFF; tx_start = 1'b1; cts0 = 1'b0; cts1 = 1'b0; step();
        en = 1'b0; tx_start = 1'b0;
        repeat (60) step();
        chk("t4_no_second_rts0", int'(rts0), 0);
        chk("t4_no_second_rts1", int'(rts1), 0);
        follow[0] = 1'b1; follow[1] = 1'b1;
        tx_start = 1'b1; step();
        tx_start = 1'b0;
        expect_frame(0, 10'b1111111110, "t4_ff");
        repeat (50) step();

        // Four clocks per bit, 0xA5.
        en = 1'b1; data = 8'hA5; step();
        en = 1'b0; tx_start = 1'b1; step();
        tx_start = 1'b0;
        expect_frame(1, 10'b1101001010, "t5_a5");
        repeat (50) step();

        // Reset during data bit 3, then confirm the holding register was cleared.
        en = 1'b1; data = 8'h3C; step();
        en = 1'b0; tx_start = 1'b1; step();
        tx_start = 1'b0;
        w = 0;
        while (ser0 !== 1'b0 && w < 50) begin
            step();
            w++;
        end
        chk("t6_start_seen", int'(w < 50), 1);
        repeat (4) step();
        rst = 1'b0; step();
        rst = 1'b1;
        chk("t6_rts_after_rst", int'(rts0), 0);
        chk("t6_ser_after_rst", int'(ser0), 1);
        tx_start = 1'b1; step();
        tx_start = 1'b0;
        expect_frame(0, 10'b1000000000, "t6_zero");
        repeat (50) step();

        // Random traffic checked cycle by cycle against the model.
        for (int blk = 0; blk < 8; blk++) begin
            follow[0] = ($urandom_range(0, 1) == 1);
            follow[1] = ($urandom_range(0, 1) == 1);
            for (int c = 0; c < 100; c++) begin
                en       = ($urandom_range(0, 7) == 0);
                data     = 8'($urandom);
                tx_start = ($urandom_range(0, 5) == 0);
                rst      = ($urandom_range(0, 299) != 0);
                if (!follow[0]) cts0 = ($urandom_range(0, 3) != 0);
                if (!follow[1]) cts1 = ($urandom_range(0, 3) != 0);
                step();
            end
        end

        // Drain.
        rst = 1'b1; en = 1'b0; tx_start = 1'b0;
        follow[0] = 1'b1; follow[1] = 1'b1;
        repeat (100) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cep_uart_tx.md
Name: cep_uart_tx

Overview:
- UART transmitter with an RTS/CTS hardware handshake.
- `en` loads a byte into a holding register.
- `tx_start` raises RTS. Once the peer returns CTS, the held byte goes out as an 8N1 frame on `serial_out`: start bit 0, 8 data bits LSB first, stop bit 1.
- Sits between a byte-producing core and the serial line driver / flow-control pins.

Parameters:
- CLKS_PER_BIT, default 1: CLK cycles each serial bit is held. Legal values are 1 to 65535.

Ports:
- CLK  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-low reset.
- en  input  1  load strobe; `data` is captured into the holding register on every CLK edge where en=1.
- tx_start  input  1  transmit request; sampled only in IDLE.
- data  input  8  parallel byte to send.
- CTS  input  1  clear-to-send from the peer; may be asynchronous and is sampled directly (no synchronizer inside this block).
- RTS  output  1  request-to-send; high from request until the end of the stop bit.
- serial_out  output  1  serial line; idle level 1.

Behaviour:
- Interface: one clock (CLK); reset rst is synchronous and active-low.
- Reset (rst=0 at a CLK edge):
  - state=IDLE, RTS=0, serial_out=1.
  - Holding register, shift register, bit counter and baud counter all cleared to 0.
  - Reset mid-frame aborts the frame immediately, with serial_out=1 on the next cycle.
- Holding register:
  - Loads `data` whenever en=1, in any state.
  - It is never changed by transmission.
  - A byte is sent as many times as tx_start is accepted.
- Shift register:
  - Copied from the holding register on the REQ->START transition only.
  - Loading the holding register with en during a frame does not corrupt the frame in flight.
- All outputs are registered, with no combinational path from inputs to outputs.
- FSM states and transitions:
  - IDLE: RTS=0, serial_out=1. tx_start=1 -> REQ.
  - REQ: RTS=1, serial_out=1. CTS=1 -> START, and the shift register is loaded. Waits indefinitely while CTS=0.
  - START: serial_out=0 for CLKS_PER_BIT cycles, then -> DATA with bit index 0.
  - DATA: serial_out=shift[0] for CLKS_PER_BIT cycles, then shift right and index+1. After bit 7 -> STOP.
  - STOP: serial_out=1 for CLKS_PER_BIT cycles, then -> IDLE. RTS drops to 0 on entry to IDLE.
- Latency:
  - tx_start seen at edge n gives RTS=1 from edge n+1.
  - CTS=1 seen in REQ at edge m gives the start bit from edge m+1.
  - The frame lasts 10*CLKS_PER_BIT cycles.
- Baud counter: counts 0..CLKS_PER_BIT-1 and resets at each bit boundary. CLKS_PER_BIT=1 means one bit per cycle.
- Boundary conditions:
  - CTS falling during START/DATA/STOP is ignored; the frame completes.
  - tx_start while not in IDLE is ignored and not queued.
  - tx_start held high across the return to IDLE starts a new request on the next cycle.
  - en and tx_start asserted in the same cycle: the byte is loaded and the request accepted. The frame carries the newly loaded byte, since the load precedes the REQ->START copy.
  - tx_start with no prior en sends the reset value 0x00.
  - CTS already high when REQ is entered: START begins on the following edge, so REQ lasts one cycle.

Test Plan:
1. Reset: rst=0 for 1 cycle, then rst=1 with tx_start=0 -> RTS=0, serial_out=1 held indefinitely.
2. Load and send, CLKS_PER_BIT=1:
   - Stimulus: en=1 with data=0x6B, then data changes to 0x00 without en; tx_start pulse; CTS tied to RTS through a one-cycle register.
   - Response: RTS rises; serial_out sequence is 0,1,1,0,1,0,1,1,0,1; RTS falls after the stop bit. Holding is not reloaded without en.
3. Flow control: hold CTS=0 for 20 cycles after tx_start -> RTS=1 and serial_out=1 throughout. Raise CTS -> start bit on the next cycle.
4. Mid-frame disturbance:
   - Stimulus: during data bits, set en=1 with data=0xFF, pulse tx_start, drop CTS.
   - Response: the current frame still shows the 0x00 pattern (0, then eight 0s, then 1). No second frame follows unless tx_start is asserted in IDLE; a later frame sends 0xFF.
5. CLKS_PER_BIT=4, data=0xA5 -> each bit held exactly 4 cycles; frame of 40 cycles; bit sequence 0,1,0,1,0,0,1,0,1,1.
6. Reset during DATA bit 3 -> next cycle RTS=0, serial_out=1, state IDLE, holding=0x00.
